// File: rtl/uart_rx_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Parametrised UART receiver (data width, parity, stop bits) with
//             per-frame error flags and a first-word-fall-through frame FIFO.
//             Optional build macro: UART_RX_MAJORITY_EN (3-sample bit vote).
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_PER_BIT = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_serial,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count
);

    localparam int CNT_W   = $clog2(CLK_PER_BIT);
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] c_half_cnt = CNT_W'((CLK_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DATA_BITS - 1);
    localparam logic             c_last_stp = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    logic                 sync1_q, rxs_q;
    logic [1:0]           settle_q;
    logic                 armed_q;
    logic                 w_sample;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stp_q, stp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 w_wr;
    logic [ENTRY_W-1:0]   w_entry;

    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W:0]       wptr_q, rptr_q;
    logic                 overrun_q;
    logic                 w_empty, w_full, w_pop, w_push;
    logic [ENTRY_W-1:0]   w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            rxs_q   <= sync1_q;
        end
    end

    // The synchroniser resets high, so the real line level is only known
    // after it has flushed; arm start detection once that level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
            if (settle_q == 2'd2 && rxs_q) armed_q <= 1'b1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // sync1_q already holds the value rxs_q takes next cycle, giving the +1
    // sample without adding latency.
    logic rxs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rxs_prev_q <= 1'b1;
        else        rxs_prev_q <= rxs_q;
    end

    assign w_sample = (rxs_prev_q & rxs_q) | (rxs_q & sync1_q) | (rxs_prev_q & sync1_q);
`else
    assign w_sample = rxs_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stp_q   <= 1'b0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stp_q   <= stp_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        stp_d   = stp_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        w_wr    = 1'b0;
        w_entry = {ferr_q | ~w_sample, perr_q, shift_q};
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                stp_d  = 1'b0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                if (armed_q && !rxs_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == c_half_cnt) begin
                    cnt_d   = '0;
                    state_d = w_sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == c_last_cnt) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = w_sample;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == c_last_idx) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt_q == c_last_cnt) begin
                    cnt_d   = '0;
                    perr_d  = (PARITY == 1) ? ~(^shift_q ^ w_sample) : (^shift_q ^ w_sample);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == c_last_cnt) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~w_sample;
                    if (stp_q == c_last_stp) begin
                        w_wr    = 1'b1;
                        state_d = w_sample ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        stp_d = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign w_pop   = !w_empty && rx_ready;
    // A same-cycle pop frees the slot a full FIFO needs for the new frame.
    assign w_push  = w_wr && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (w_push) begin
                mem_q[wptr_q[PTR_W-1:0]] <= w_entry;
                wptr_q                   <= wptr_q + 1'b1;
            end
            if (w_pop) rptr_q <= rptr_q + 1'b1;
            overrun_q <= w_wr && w_full && !w_pop;
        end
    end

    assign w_head        = mem_q[rptr_q[PTR_W-1:0]];
    assign rx_data       = w_head[DATA_BITS-1:0];
    assign rx_parity_err = w_head[DATA_BITS];
    assign rx_frame_err  = w_head[DATA_BITS+1];
    assign rx_valid      = !w_empty;
    assign rx_overrun    = overrun_q;
    assign rx_count      = wptr_q - rptr_q;

endmodule
`default_nettype wire
